// File: rtl/sniffer_pkg.sv
// sniffer_pkg: shared types and constants for the packet frame sequencer.
//   state_t        - sequencer FSM states
//   *_D constants  - default compare-window word indices
//   RW_* constants - bit positions of the fields in result_word
//   in_win()       - inclusive word-window test
package sniffer_pkg;
    typedef enum logic [2:0] {CONFIG, IDLE, ACTIVE, COMMIT, WRITE, CLEAR} state_t;
    localparam logic [15:0] MAC_FIRST_D  = 16'd0;
    localparam logic [15:0] MAC_LAST_D   = 16'd2;
    localparam logic [15:0] IP_FIRST_D   = 16'd6;
    localparam logic [15:0] IP_LAST_D    = 16'd8;
    localparam logic [15:0] PORT_FIRST_D = 16'd8;
    localparam logic [15:0] PORT_LAST_D  = 16'd9;
    localparam logic [15:0] URL_FIRST_D  = 16'd13;
    localparam int RW_MAC  = 0;
    localparam int RW_IP   = 1;
    localparam int RW_PORT = 2;
    localparam int RW_URL  = 3;
    localparam int RW_IDX  = 4;
    // Unsigned wrap-around trick: an index below first wraps to a huge value
    // and so falls outside the window without a separate lower-bound compare.
    function automatic logic in_win(input logic [15:0] idx, input logic [15:0] first,
                                    input logic [15:0] last);
        return 16'(idx - first) <= 16'(last - first);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter that sticks at all-ones.
//   clk, n_rst - clock, asynchronous active-low reset
//   inc        - count request (ignored once saturated)
//   cnt        - current count
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: rtl/packet_frame_sequencer.sv
// packet_frame_sequencer: per-packet sequencer for the sniffer datapath.
//   clk, n_rst                    - clock, asynchronous active-low reset
//   valid, sop, eop, empty, error - Avalon-ST sink (empty is pass-through only)
//   ready                         - Avalon-ST sink ready
//   update_done                   - configuration complete pulse, leaves CONFIG
//   *_match                       - comparator results, one cycle after the enabled beat
//   *_en                          - comparator compare-window enables
//   clear                         - comparator clear pulse after each packet
//   write_enable, inc_addr        - result write strobe and address advance
//   result_word                   - {pkt_idx[27:0], url, port, ip, mac}
//   *_hits                        - saturating per-category hit counters
module packet_frame_sequencer
    import sniffer_pkg::*;
#(
    parameter logic [15:0] MAC_FIRST  = MAC_FIRST_D,
    parameter logic [15:0] MAC_LAST   = MAC_LAST_D,
    parameter logic [15:0] IP_FIRST   = IP_FIRST_D,
    parameter logic [15:0] IP_LAST    = IP_LAST_D,
    parameter logic [15:0] PORT_FIRST = PORT_FIRST_D,
    parameter logic [15:0] PORT_LAST  = PORT_LAST_D,
    parameter logic [15:0] URL_FIRST  = URL_FIRST_D,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             valid,
    input  logic             sop,
    input  logic             eop,
    input  logic [1:0]       empty,
    input  logic [5:0]       error,
    input  logic             update_done,
    input  logic             mac_match,
    input  logic             ip_match,
    input  logic             port_match,
    input  logic             url_match,
    output logic             ready,
    output logic             mac_en,
    output logic             ip_en,
    output logic             port_en,
    output logic             url_en,
    output logic             clear,
    output logic             inc_addr,
    output logic             write_enable,
    output logic [31:0]      result_word,
    output logic [CNT_W-1:0] port_hits,
    output logic [CNT_W-1:0] ip_hits,
    output logic [CNT_W-1:0] mac_hits,
    output logic [CNT_W-1:0] url_hits
);
    state_t      state, state_n;
    logic [15:0] word_cnt, idx;
    logic [27:0] pkt_idx;
    logic [3:0]  hit, hit_now;
    logic        err_q, acc, first, in_pkt, bump;
    logic        unused_ok;

    assign unused_ok = ^empty;

    always_comb begin
        ready   = state == IDLE || state == ACTIVE;
        acc     = valid && ready;
        // An accepted sop starts a packet from IDLE or restarts one from ACTIVE.
        first   = acc && sop;
        in_pkt  = acc && (state == ACTIVE || first);
        idx     = sop ? 16'd0 : word_cnt;
        mac_en  = in_pkt && in_win(idx, MAC_FIRST, MAC_LAST);
        ip_en   = in_pkt && in_win(idx, IP_FIRST, IP_LAST);
        port_en = in_pkt && in_win(idx, PORT_FIRST, PORT_LAST);
        url_en  = in_pkt && idx >= URL_FIRST;
        // Fold in this cycle's matches so a hit on the last beat counts in COMMIT.
        hit_now = hit;
        hit_now[RW_MAC]  = hit[RW_MAC] | mac_match;
        hit_now[RW_IP]   = hit[RW_IP] | ip_match;
        hit_now[RW_PORT] = hit[RW_PORT] | port_match;
        hit_now[RW_URL]  = hit[RW_URL] | url_match;
        bump         = state == COMMIT && !err_q;
        write_enable = state == WRITE;
        inc_addr     = state == WRITE;
        clear        = state == CLEAR;
        state_n      = state;
        case (state)
            CONFIG:  state_n = update_done ? IDLE : CONFIG;
            IDLE:    state_n = first ? (eop ? COMMIT : ACTIVE) : IDLE;
            ACTIVE:  state_n = acc && eop ? COMMIT : ACTIVE;
            COMMIT:  state_n = bump && |hit_now ? WRITE : CLEAR;
            WRITE:   state_n = CLEAR;
            CLEAR:   state_n = IDLE;
            default: state_n = CONFIG;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= CONFIG;
            word_cnt    <= '0;
            hit         <= '0;
            err_q       <= 1'b0;
            pkt_idx     <= '0;
            result_word <= '0;
        end else begin
            state <= state_n;
            if (first) word_cnt <= 16'd1;
            else if (acc && state == ACTIVE && word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
            if (first || state == CLEAR) hit <= '0;
            else if (state == ACTIVE || state == COMMIT) hit <= hit_now;
            if (in_pkt && eop) err_q <= |error;
            if (bump) pkt_idx <= pkt_idx + 28'd1;
            if (bump && |hit_now) result_word <= {pkt_idx + 28'd1, hit_now};
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_mac  (.clk(clk), .n_rst(n_rst), .inc(bump && hit_now[RW_MAC]),  .cnt(mac_hits));
    sat_counter #(.CNT_W(CNT_W)) u_ip   (.clk(clk), .n_rst(n_rst), .inc(bump && hit_now[RW_IP]),   .cnt(ip_hits));
    sat_counter #(.CNT_W(CNT_W)) u_port (.clk(clk), .n_rst(n_rst), .inc(bump && hit_now[RW_PORT]), .cnt(port_hits));
    sat_counter #(.CNT_W(CNT_W)) u_url  (.clk(clk), .n_rst(n_rst), .inc(bump && hit_now[RW_URL]),  .cnt(url_hits));
endmodule

// File: tb/tb_packet_frame_sequencer.sv
// tb_packet_frame_sequencer: directed, table-driven bench for packet_frame_sequencer.
// Counters are built 4 bits wide so saturation is reachable in a short run.
module tb_packet_frame_sequencer;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          valid = 1'b0, sop = 1'b0, eop = 1'b0, update_done = 1'b0;
    logic [1:0]    empty = 2'd0;
    logic [5:0]    error = 6'd0;
    logic          mac_match = 1'b0, ip_match = 1'b0, port_match = 1'b0, url_match = 1'b0;
    logic          ready, mac_en, ip_en, port_en, url_en, clear, inc_addr, write_enable;
    logic [31:0]   result_word;
    logic [CW-1:0] port_hits, ip_hits, mac_hits, url_hits;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic v, s, e;
        logic [3:0] m;
        logic upd, rdy;
        logic [3:0] en;
        logic we, clr;
    } vec_t;
    vec_t tbl[$];

    // Expected {url,port,ip,mac} enables for accepted beats at word 0..15.
    logic [3:0] exp_en [16] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2,
                                4'h6, 4'h4, 4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8};

    packet_frame_sequencer #(.CNT_W(CW)) dut (
        .clk(clk), .n_rst(n_rst), .valid(valid), .sop(sop), .eop(eop), .empty(empty),
        .error(error), .update_done(update_done), .mac_match(mac_match), .ip_match(ip_match),
        .port_match(port_match), .url_match(url_match), .ready(ready), .mac_en(mac_en),
        .ip_en(ip_en), .port_en(port_en), .url_en(url_en), .clear(clear), .inc_addr(inc_addr),
        .write_enable(write_enable), .result_word(result_word), .port_hits(port_hits),
        .ip_hits(ip_hits), .mac_hits(mac_hits), .url_hits(url_hits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic add(input logic v, input logic s, input logic e, input logic [3:0] m,
                       input logic upd, input logic rdy, input logic [3:0] en,
                       input logic we, input logic clr);
        vec_t t;
        t.v = v; t.s = s; t.e = e; t.m = m; t.upd = upd;
        t.rdy = rdy; t.en = en; t.we = we; t.clr = clr;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [5:0] err,
                         input logic [3:0] m);
        valid = v; sop = s; eop = e; error = err;
        {url_match, port_match, ip_match, mac_match} = m;
    endtask

    // One packet of len beats (sop at 0 and at sop2, eop at len-1); mask driven on the
    // matches the cycle after beat m_word. Counts write/clear pulses until back in IDLE.
    task automatic send_pkt(input int len, input int sop2, input logic [5:0] err,
                            input logic [3:0] mask, input int m_word,
                            output int wen, output int clrn, output int stall);
        wen = 0; clrn = 0; stall = 0;
        for (int c = 0; c < len + 4; c++) begin
            @(negedge clk);
            drive(c < len, c == 0 || c == sop2, c == len - 1, c == len - 1 ? err : 6'd0,
                  c == m_word + 1 ? mask : 4'h0);
            #1;
            if (c < len && !ready) stall++;
            if (write_enable && inc_addr) wen++;
            if (clear) clrn++;
        end
        @(negedge clk);
        drive(0, 0, 0, 6'd0, 4'h0);
    endtask

    int wen, clrn, stall, exp_idx;

    initial begin
        drive(0, 0, 0, 6'd0, 4'h0);
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_result", result_word, 0);
        chk("rst_hits", {16'd0, mac_hits, ip_hits, port_hits, url_hits}, 0);
        chk("rst_pulses", {clear, inc_addr, write_enable}, 0);
        n_rst = 1'b1;

        add(0, 0, 0, 4'h0, 1, 0, 4'h0, 0, 0);
        add(1, 0, 0, 4'h0, 0, 1, 4'h0, 0, 0);
        for (int w = 0; w < 16; w++)
            add(1, w == 0, w == 15, w == 2 ? 4'h1 : 4'h0, 0, 1, exp_en[w], 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 4'h0, 1, 0);
        add(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 1);
        for (int w = 0; w < 12; w++) begin
            if (w >= 7 && w <= 10) add(0, 0, 0, 4'h0, 0, 1, 4'h0, 0, 0);
            add(1, w == 0, w == 11, 4'h0, 0, 1, exp_en[w], 0, 0);
        end
        add(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h0, 0, 1, 4'h0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].s, tbl[i].e, 6'd0, tbl[i].m);
            update_done = tbl[i].upd;
            #1;
            chk($sformatf("tbl%0d_ready", i), 32'(ready), 32'(tbl[i].rdy));
            chk($sformatf("tbl%0d_en", i), 32'({url_en, port_en, ip_en, mac_en}), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_we", i), 32'(write_enable), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_inc", i), 32'(inc_addr), 32'(tbl[i].we));
            chk($sformatf("tbl%0d_clr", i), 32'(clear), 32'(tbl[i].clr));
        end
        update_done = 1'b0;
        chk("t1_mac_hits", 32'(mac_hits), 1);
        chk("t1_result", result_word, 32'h0000_0011);
        chk("t1_other_hits", 32'({ip_hits, port_hits, url_hits}), 0);

        send_pkt(12, -1, 6'd0, 4'h0, -5, wen, clrn, stall);
        chk("t2_we", 32'(wen), 0);
        chk("t2_clear", 32'(clrn), 1);
        chk("t2_stall", 32'(stall), 0);
        chk("t2_hits", 32'({mac_hits, ip_hits, port_hits, url_hits}), 32'h1000);

        send_pkt(16, -1, 6'h01, 4'h8, 15, wen, clrn, stall);
        chk("t3_we", 32'(wen), 0);
        chk("t3_clear", 32'(clrn), 1);
        chk("t3_url_hits", 32'(url_hits), 0);
        chk("t3_result", result_word, 32'h0000_0011);

        send_pkt(15, 5, 6'd0, 4'h2, 2, wen, clrn, stall);
        chk("t4_we", 32'(wen), 0);
        chk("t4_clear", 32'(clrn), 1);
        chk("t4_ip_hits", 32'(ip_hits), 0);

        exp_idx = 4;
        for (int p = 1; p <= 16; p++) begin
            send_pkt(10, -1, 6'd0, 4'h4, 9, wen, clrn, stall);
            exp_idx++;
            chk($sformatf("t6_we%0d", p), 32'(wen), 1);
            chk($sformatf("t6_clear%0d", p), 32'(clrn), 1);
            chk($sformatf("t6_port_hits%0d", p), 32'(port_hits), p < 15 ? p : 15);
            chk($sformatf("t6_result%0d", p), result_word, {28'(exp_idx), 4'h4});
        end
        chk("t6_final_hits", 32'({mac_hits, ip_hits, url_hits}), 32'h100);

        @(negedge clk);
        drive(1, 1, 0, 6'd0, 4'h0);
        @(negedge clk);
        drive(1, 0, 0, 6'd0, 4'h0);
        #1;
        chk("t6_pre_rst_mac_en", 32'(mac_en), 1);
        #1 n_rst = 1'b0;
        #1;
        chk("t6_arst_ready", 32'(ready), 0);
        chk("t6_arst_en", 32'({url_en, port_en, ip_en, mac_en}), 0);
        chk("t6_arst_hits", 32'({mac_hits, ip_hits, port_hits, url_hits}), 0);
        chk("t6_arst_result", result_word, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_config_ready", 32'(ready), 0);
        drive(0, 0, 0, 6'd0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
